pc_fetch_sequencer: RTL

Fetch/execute sequencer for the RISCuinho core. It drives the enable and branch-select inputs of the program counter unit. It runs the instruction-memory read handshake and holds the fetched instruction in an instruction register until the execute stage accepts it. It also handles halt, end-of-address-space and run/stop control, and counts retired instructions.

---
 rtl/pc_fetch_sequencer.sv | 87 ++++++++
 1 files changed

// File: rtl/pc_fetch_sequencer.sv
// Fetch/execute sequencer for the RISCuinho core: runs the imem read handshake,
// holds the instruction register, drives PC-unit enable/select, counts retirements.
module pc_fetch_sequencer #(
  parameter int INSTR_ADDR_WIDTH = 20,
  parameter int INSTR_WIDTH      = 32,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  input  logic                        halt_req,
  input  logic [INSTR_ADDR_WIDTH-1:0] pc,
  input  logic                        pc_end,
  output logic                        pc_en,
  output logic                        pc_src,
  output logic                        imem_req,
  output logic [INSTR_ADDR_WIDTH-1:0] imem_addr,
  input  logic                        imem_ack,
  input  logic [INSTR_WIDTH-1:0]      imem_rdata,
  output logic [INSTR_WIDTH-1:0]      ir,
  output logic                        ir_valid,
  input  logic                        ex_ready,
  input  logic                        branch_taken,
  output logic                        halted,
  output logic [CNT_WIDTH-1:0]        retired
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t state, state_nxt;
  logic   retire;
  logic   at_end;

  // reset wins over a same-cycle retirement, so the PC never moves under rst
  assign retire    = (state == EXEC) && ex_ready && !rst;
  assign at_end    = pc_end && !branch_taken;
  assign imem_addr = pc;
  assign halted    = (state == HALT);

  always_comb begin
    state_nxt = state;
    pc_en     = 1'b0;
    pc_src    = 1'b0;
    imem_req  = 1'b0;
    case (state)
      IDLE: begin
        if (halt_req)  state_nxt = HALT;
        else if (run)  state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = EXEC;
      end
      EXEC: begin
        if (retire) begin
          pc_src = branch_taken;
          pc_en  = !at_end;
          if (halt_req || at_end) state_nxt = HALT;
          else if (!run)          state_nxt = IDLE;
          else                    state_nxt = FETCH;
        end
      end
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ir       <= '0;
      ir_valid <= 1'b0;
      retired  <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && imem_ack) begin
        ir       <= imem_rdata;
        ir_valid <= 1'b1;
      end
      if (retire) begin
        ir_valid <= 1'b0;
        retired  <= retired + 1'b1;
      end
    end
  end

endmodule
